// File: rtl/cache_pkg.sv
// Shared types and default sizing for the L1 cache controller and its line array.
package cache_pkg;

    localparam int INDEX_BITS = 4;
    localparam int TAG_W      = 32 - INDEX_BITS;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        WRITE_MEM = 3'd4
    } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/tag/data per line, combinational read, one write port.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = cache_pkg::INDEX_BITS,
    parameter int TAG_W      = 32 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [31:0]      data_mem [LINES];

    // Only the valid bits need clearing; stale tag/data behind a clear bit are never used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/l1_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 cache between the CPU and main memory.
module l1_cache_controller
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = cache_pkg::INDEX_BITS,
    parameter int CNT_W      = cache_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req_valid,
    output logic             cpu_req_ready,
    input  logic             cpu_req_write,
    input  logic [31:0]      cpu_req_addr,
    input  logic [31:0]      cpu_req_wdata,
    output logic             cpu_resp_valid,
    output logic [31:0]      cpu_resp_rdata,
    output logic [31:0]      mem_address,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [31:0]      mem_data_out,
    input  logic [31:0]      mem_data_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int LTAG_W = 32 - INDEX_BITS;

    state_t state_reg, state_next;

    logic              req_write_reg;
    logic [31:0]       req_addr_reg;
    logic [31:0]       req_wdata_reg;

    logic              resp_valid_reg, resp_valid_next;
    logic [31:0]       resp_rdata_reg, resp_rdata_next;
    logic [31:0]       mem_address_reg, mem_address_next;
    logic              mem_read_en_reg, mem_read_en_next;
    logic              mem_write_en_reg, mem_write_en_next;
    logic [31:0]       mem_data_out_reg, mem_data_out_next;
    logic [CNT_W-1:0]  hit_count_reg, hit_count_next;
    logic [CNT_W-1:0]  miss_count_reg, miss_count_next;

    logic [INDEX_BITS-1:0] req_index;
    logic [LTAG_W-1:0]     req_tag;
    logic                  rd_valid;
    logic [LTAG_W-1:0]     rd_tag;
    logic [31:0]           rd_data;
    logic                  lookup_hit;
    logic                  wr_en;
    logic [31:0]           wr_data;

    assign req_index  = req_addr_reg[INDEX_BITS-1:0];
    assign req_tag    = req_addr_reg[31:INDEX_BITS];
    assign lookup_hit = rd_valid && (rd_tag == req_tag);

    cache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (LTAG_W)
    ) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            req_write_reg    <= 1'b0;
            req_addr_reg     <= '0;
            req_wdata_reg    <= '0;
            resp_valid_reg   <= 1'b0;
            resp_rdata_reg   <= '0;
            mem_address_reg  <= '0;
            mem_read_en_reg  <= 1'b0;
            mem_write_en_reg <= 1'b0;
            mem_data_out_reg <= '0;
            hit_count_reg    <= '0;
            miss_count_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            resp_valid_reg   <= resp_valid_next;
            resp_rdata_reg   <= resp_rdata_next;
            mem_address_reg  <= mem_address_next;
            mem_read_en_reg  <= mem_read_en_next;
            mem_write_en_reg <= mem_write_en_next;
            mem_data_out_reg <= mem_data_out_next;
            hit_count_reg    <= hit_count_next;
            miss_count_reg   <= miss_count_next;
            if (state_reg == IDLE && cpu_req_valid) begin
                req_write_reg <= cpu_req_write;
                req_addr_reg  <= cpu_req_addr;
                req_wdata_reg <= cpu_req_wdata;
            end
        end
    end

    // Registered outputs are computed one state ahead so each pulse lands in the named state.
    always_comb begin
        state_next        = state_reg;
        resp_valid_next   = 1'b0;
        resp_rdata_next   = resp_rdata_reg;
        mem_address_next  = mem_address_reg;
        mem_read_en_next  = 1'b0;
        mem_write_en_next = 1'b0;
        mem_data_out_next = mem_data_out_reg;
        hit_count_next    = hit_count_reg;
        miss_count_next   = miss_count_reg;
        wr_en             = 1'b0;
        wr_data           = req_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_write_reg) begin
                    state_next        = WRITE_MEM;
                    mem_write_en_next = 1'b1;
                    mem_address_next  = req_addr_reg;
                    mem_data_out_next = req_wdata_reg;
                end else if (lookup_hit) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = rd_data;
                    hit_count_next  = (&hit_count_reg) ? hit_count_reg : hit_count_reg + 1'b1;
                end else begin
                    state_next       = FILL_REQ;
                    mem_read_en_next = 1'b1;
                    mem_address_next = req_addr_reg;
                    miss_count_next  = (&miss_count_reg) ? miss_count_reg : miss_count_reg + 1'b1;
                end
            end
            FILL_REQ: begin
                state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                state_next      = IDLE;
                wr_en           = 1'b1;
                wr_data         = mem_data_in;
                resp_valid_next = 1'b1;
                resp_rdata_next = mem_data_in;
            end
            WRITE_MEM: begin
                // The line is unchanged since LOOKUP, so the hit can be re-evaluated here.
                state_next      = IDLE;
                wr_en           = lookup_hit;
                resp_valid_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_req_ready  = (state_reg == IDLE);
    assign cpu_resp_valid = resp_valid_reg;
    assign cpu_resp_rdata = resp_rdata_reg;
    assign mem_address    = mem_address_reg;
    assign mem_read_en    = mem_read_en_reg;
    assign mem_write_en   = mem_write_en_reg;
    assign mem_data_out   = mem_data_out_reg;
    assign hit_count      = hit_count_reg;
    assign miss_count     = miss_count_reg;

endmodule

// File: tb/tb_l1_cache_controller.sv
// Scoreboard bench: driver feeds a reference model that queues expected responses and memory ops.
module tb_l1_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_write = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in = '0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    l1_cache_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_write  (cpu_req_write),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_address    (mem_address),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int resp_num = 0;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
    } memop_t;

    resp_t  resp_q[$];
    memop_t mop_q[$];

    // Environment memory with a registered 1-cycle read, as the real main memory behaves.
    logic [31:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_write_en) env_mem[mem_address[7:0]] <= mem_data_out;
        if (mem_read_en)  mem_data_in <= env_mem[mem_address[7:0]];
    end

    // Reference model: which address each line holds; data comes from the model's memory view.
    logic [31:0] ref_mem [256];
    int          line_addr [16];
    logic [31:0] last_rdata;
    int          m_hits;
    int          m_miss;

    function automatic logic [31:0] init_val(input int a);
        logic [31:0] v;
        v = 32'(a) * 32'h9E3779B1 ^ 32'h5A5A0000;
        if (a == 0) v = 32'h00221800;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) line_addr[i] = -1;
        last_rdata = '0;
        m_hits = 0;
        m_miss = 0;
        resp_q.delete();
        mop_q.delete();
    endtask

    task automatic model_req(input bit w, input logic [31:0] a, input logic [31:0] d, input int acc);
        int idx;
        resp_t r;
        memop_t m;
        idx = int'(a[3:0]);
        r.acc = acc;
        if (w) begin
            ref_mem[a[7:0]] = d;
            m.w = 1'b1; m.addr = a; m.data = d;
            mop_q.push_back(m);
            r.rdata = last_rdata;
            r.lat = 2;
        end else if (line_addr[idx] == int'(a)) begin
            if (m_hits < 65535) m_hits++;
            r.rdata = ref_mem[a[7:0]];
            r.lat = 1;
        end else begin
            if (m_miss < 65535) m_miss++;
            line_addr[idx] = int'(a);
            m.w = 1'b0; m.addr = a; m.data = '0;
            mop_q.push_back(m);
            r.rdata = ref_mem[a[7:0]];
            r.lat = 3;
        end
        last_rdata = r.rdata;
        resp_q.push_back(r);
    endtask

    resp_t  mon_r;
    memop_t mon_m;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_r = resp_q.pop_front();
                    resp_num++;
                    $display("resp %0d: rdata=%h lat=%0d", resp_num, cpu_resp_rdata, cycle - mon_r.acc);
                    chk("resp_rdata", cpu_resp_rdata, mon_r.rdata);
                    chk("resp_latency", 32'(cycle - mon_r.acc), 32'(mon_r.lat));
                end
            end
            if (mem_read_en && mem_write_en) begin
                chk("mem_both_en", 32'd1, 32'd0);
            end else if (mem_read_en || mem_write_en) begin
                if (mop_q.size() == 0) begin
                    chk("mem_unexpected", {31'd0, mem_write_en}, 32'hFFFFFFFF);
                end else begin
                    mon_m = mop_q.pop_front();
                    chk("mem_kind_write", {31'd0, mem_write_en}, {31'd0, mon_m.w});
                    chk("mem_addr", mem_address, mon_m.addr);
                    if (mon_m.w) chk("mem_wdata", mem_data_out, mon_m.data);
                end
            end
        end
    end

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
        int waited = 0;
        cpu_req_valid = 1'b1;
        cpu_req_write = w;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        while (!cpu_req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cpu_req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cpu_req_valid = 1'b0;
            return;
        end
        model_req(w, a, d, cycle + 1);
        @(negedge clk);
        chk("ready_busy", {31'd0, cpu_req_ready}, 32'd0);
        cpu_req_valid = 1'b0;
        cpu_req_write = 1'($urandom_range(0, 1));
        cpu_req_addr  = $urandom;
        cpu_req_wdata = $urandom;
    endtask

    task automatic drain();
        int waited = 0;
        while ((resp_q.size() != 0 || mop_q.size() != 0) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_resp_left", 32'(resp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_counters();
        chk("hit_count", 32'(hit_count), 32'(m_hits));
        chk("miss_count", 32'(miss_count), 32'(m_miss));
    endtask

    task automatic check_reset_values();
        chk("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("rst_resp_rdata", cpu_resp_rdata, 32'd0);
        chk("rst_read_en", {31'd0, mem_read_en}, 32'd0);
        chk("rst_write_en", {31'd0, mem_write_en}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data_out", mem_data_out, 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // stage 0: reset while the fill read is on the bus; stage 1: reset while waiting for data.
    task automatic reset_midop(input int stage);
        logic [31:0] a;
        a = 32'h20 + 32'(stage);
        issue(1'b0, a, 32'd0);
        @(posedge clk);
        if (stage == 1) @(posedge clk);
        #1;
        if (stage == 0) chk("midop_read_en_before", {31'd0, mem_read_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, a, 32'd0);
        drain();
        check_counters();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'h0, 32'h0);
        drain();
        chk("t1_rdata", cpu_resp_rdata, 32'h00221800);
        chk("t1_miss", 32'(miss_count), 32'd1);

        issue(1'b0, 32'h0, 32'h0);
        drain();
        chk("t2_hit", 32'(hit_count), 32'd1);

        issue(1'b1, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 32'h0, 32'h0);
        issue(1'b0, 32'h10, 32'h0);
        issue(1'b0, 32'h0, 32'h0);
        drain();
        check_counters();

        issue(1'b1, 32'h0, 32'h12345678);
        issue(1'b0, 32'h0, 32'h0);
        drain();
        chk("t4_rdata", cpu_resp_rdata, 32'h12345678);
        check_counters();

        reset_midop(1);
        reset_midop(0);

        pulse_reset();
        issue(1'b0, 32'h1, 32'h0);
        issue(1'b0, 32'h2, 32'h0);
        issue(1'b0, 32'h1, 32'h0);
        issue(1'b0, 32'h2, 32'h0);
        drain();
        chk("t6_hit", 32'(hit_count), 32'd2);
        chk("t6_miss", 32'(miss_count), 32'd2);

        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(($urandom_range(0, 9) < 3), 32'($urandom_range(0, 63)), $urandom);
        end
        drain();
        check_counters();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
